// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader: FSM state encoding,
// frame constants and the baud divider helper.
package boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         FRAME_HDR_LEN = 3;

    function automatic int calc_div(input int clock_freq, input int baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect,
// mid-bit sampling every DIV cycles, one-cycle valid / framing-error pulses.
module boot_uart_rx #(
    parameter int DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(DIV + 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev;
    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift;

    assign rx_s = sync_q[1];

    // Bit index 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
    // A start bit that reads high at its midpoint is treated as a glitch.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_q    <= 2'b11;
            rx_prev   <= 1'b1;
            active    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            rx_prev   <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (!active) begin
                if (rx_prev && !rx_s) begin
                    active  <= 1'b1;
                    cnt     <= CNT_W'(DIV / 2 - 1);
                    bit_idx <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt     <= CNT_W'(DIV - 1);
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd0) begin
                    if (rx_s)
                        active <= 1'b0;
                end else if (bit_idx <= 4'd8) begin
                    shift <= {rx_s, shift[7:1]};
                end else begin
                    active <= 1'b0;
                    if (rx_s) begin
                        rx_byte  <= shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: receives a framed image over UART, writes it to RAM as
// a Wishbone master and releases the core only after the checksum matches.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          CLOCK_FREQ = 50000000,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] LOAD_BASE  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 16384
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    input  logic        boot_mode_i,
    output logic        core_hold_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD);

    boot_state_t state, state_next;

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_frame_err;

    logic [7:0]  hold_byte;
    logic        hold_full;
    logic        err_pend;
    logic        err_flag;
    logic [7:0]  len_l;
    logic [16:0] len;
    logic [16:0] len_full;
    logic [16:0] index;
    logic [31:0] word;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic        consume;
    logic        busy;
    logic        overrun_now;

    boot_uart_rx #(.DIV(DIV)) u_rx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (uart_rx_i),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (rx_frame_err)
    );

    assign busy     = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_DATA) ||
                      (state == ST_WRITE) || (state == ST_CSUM);
    assign consume  = hold_full && ((state == ST_SYNC) || (state == ST_LEN0) ||
                      (state == ST_LEN1) || (state == ST_DATA) || (state == ST_CSUM));
    assign len_full = {1'b0, hold_byte, len_l};
    assign overrun_now = rx_valid && hold_full && !consume;

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Errors raised during WRITE are held in err_pend so the bus cycle
    // always finishes before the FSM abandons the frame.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = boot_mode_i ? ST_SYNC : ST_DONE;
            ST_SYNC:  if (hold_full && hold_byte == SYNC_BYTE) state_next = ST_LEN0;
            ST_LEN0: begin
                if (err_pend)       state_next = ST_ERR;
                else if (hold_full) state_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (err_pend)
                    state_next = ST_ERR;
                else if (hold_full) begin
                    if (len_full > 17'(MAX_WORDS)) state_next = ST_ERR;
                    else if (len_full == 17'd0)    state_next = ST_CSUM;
                    else                           state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (err_pend)                             state_next = ST_ERR;
                else if (hold_full && byte_cnt == 2'd3)   state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (ack_i) begin
                    if (err_pend || overrun_now || rx_frame_err) state_next = ST_ERR;
                    else if (index + 17'd1 == len)              state_next = ST_CSUM;
                    else                                         state_next = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (err_pend)       state_next = ST_ERR;
                else if (hold_full) state_next = (hold_byte == csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE:  state_next = ST_DONE;
            ST_ERR:   state_next = ST_SYNC;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hold_byte <= '0;
            hold_full <= 1'b0;
            err_pend  <= 1'b0;
            err_flag  <= 1'b0;
            len_l     <= '0;
            len       <= '0;
            index     <= '0;
            word      <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
        end else begin
            if (state == ST_DONE || state == ST_ERR) begin
                hold_full <= 1'b0;
                err_pend  <= 1'b0;
            end else begin
                if (rx_valid) begin
                    hold_byte <= rx_byte;
                    hold_full <= 1'b1;
                    if (overrun_now && busy)
                        err_pend <= 1'b1;
                end else if (consume) begin
                    hold_full <= 1'b0;
                end
                if (rx_frame_err && busy)
                    err_pend <= 1'b1;
            end

            if (state == ST_ERR)
                err_flag <= 1'b1;

            case (state)
                ST_SYNC: begin
                    if (consume && hold_byte == SYNC_BYTE) begin
                        err_flag <= 1'b0;
                        index    <= '0;
                        csum     <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_LEN0:  if (consume) len_l <= hold_byte;
                ST_LEN1:  if (consume) len <= len_full;
                ST_DATA: begin
                    if (consume) begin
                        word     <= {hold_byte, word[31:8]};
                        csum     <= csum ^ hold_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_WRITE: if (ack_i) index <= index + 17'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        core_hold_o = 1'b1;
        cyc_o       = 1'b0;
        stb_o       = 1'b0;
        we_o        = 1'b0;
        adr_o       = '0;
        dat_o       = '0;
        sel_o       = '0;
        busy_o      = busy;
        done_o      = 1'b0;
        err_o       = err_flag;
        case (state)
            ST_WRITE: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                adr_o = LOAD_BASE + {13'd0, index, 2'b00};
                dat_o = word;
                sel_o = 4'hF;
            end
            ST_DONE: begin
                core_hold_o = 1'b0;
                done_o      = 1'b1;
            end
            ST_ERR:  err_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed + randomized bench for boot_loader: a UART byte driver, a random-
// latency Wishbone slave, and a frame-level reference model of expected writes.
module tb_boot_loader;
    import boot_pkg::*;

    localparam int          CLK_FREQ  = 1600000;
    localparam int          BAUD_RATE = 100000;
    localparam int          DIV       = CLK_FREQ / BAUD_RATE;
    localparam int          MAX_W     = 16384;
    localparam logic [31:0] BASE      = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic        boot_mode_i = 1'b1;
    logic        ack_i = 1'b0;
    logic        core_hold_o, cyc_o, stb_o, we_o, busy_o, done_o, err_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;

    int passed = 0;
    int total  = 0;
    int stb_seen = 0;
    int bad_ctl = 0;
    bit ack_enable = 1'b1;

    logic [31:0] got_adr[$];
    logic [31:0] got_dat[$];
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_done, exp_err;
    logic [7:0]  frame[$];

    boot_loader #(
        .CLOCK_FREQ (CLK_FREQ),
        .BAUD       (BAUD_RATE),
        .LOAD_BASE  (BASE),
        .MAX_WORDS  (MAX_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .uart_rx_i   (uart_rx_i),
        .boot_mode_i (boot_mode_i),
        .core_hold_o (core_hold_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .sel_o       (sel_o),
        .ack_i       (ack_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Wishbone slave: acks at random; each granted ack is one completed write.
    always @(negedge clk) begin
        ack_i = 1'b0;
        if (stb_o) begin
            stb_seen++;
            if (!(cyc_o && we_o && sel_o == 4'hF))
                bad_ctl++;
            if (rst_i && ack_enable && $urandom_range(0, 2) == 0) begin
                ack_i = 1'b1;
                got_adr.push_back(adr_o);
                got_dat.push_back(dat_o);
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
        @(negedge clk) uart_rx_i = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx_i = !bad_stop;
        repeat (DIV) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] fb[$]);
        foreach (fb[i]) send_byte(fb[i]);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset(input logic mode);
        rst_i       = 1'b0;
        boot_mode_i = mode;
        uart_rx_i   = 1'b1;
        ack_enable  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got_adr.delete();
        got_dat.delete();
        stb_seen = 0;
        rst_i = 1'b1;
    endtask

    // Frame-level model: decode length, words and checksum straight from the byte list.
    task automatic model_frame(input logic [7:0] fb[$]);
        int          len;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_adr.delete();
        exp_dat.delete();
        len = int'(fb[1]) + 256 * int'(fb[2]);
        if (len > MAX_W) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < len; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w  = w | (32'(fb[FRAME_HDR_LEN + 4 * i + k]) << (8 * k));
                cs = cs ^ fb[FRAME_HDR_LEN + 4 * i + k];
            end
            exp_adr.push_back(BASE + 32'(4 * i));
            exp_dat.push_back(w);
        end
        exp_done = (fb[FRAME_HDR_LEN + 4 * len] == cs);
        exp_err  = !exp_done;
    endtask

    task automatic check_frame(input string tag);
        check_output({tag, "_done"}, 32'(done_o), 32'(exp_done));
        check_output({tag, "_err"}, 32'(err_o), 32'(exp_err));
        check_output({tag, "_hold"}, 32'(core_hold_o), 32'(!exp_done));
        check_output({tag, "_nwr"}, got_adr.size(), exp_adr.size());
        for (int i = 0; i < got_adr.size() && i < exp_adr.size(); i++) begin
            check_output({tag, "_adr"}, got_adr[i], exp_adr[i]);
            check_output({tag, "_dat"}, got_dat[i], exp_dat[i]);
        end
        got_adr.delete();
        got_dat.delete();
    endtask

    task automatic wait_stb(input string tag);
        for (int c = 0; c < 3000 && !stb_o; c++) @(negedge clk);
        check_output(tag, 32'(stb_o), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int         n;

        // Reset values
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_hold", 32'(core_hold_o), 32'd1);
        check_output("rst_ctl", {29'd0, cyc_o, stb_o, we_o}, 32'd0);
        check_output("rst_flags", {29'd0, busy_o, done_o, err_o}, 32'd0);
        check_output("rst_adr", adr_o, 32'd0);
        check_output("rst_dat", dat_o, 32'd0);
        check_output("rst_sel", 32'(sel_o), 32'd0);

        // Bypass: RX ignored once done
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        check_output("byp_done", 32'(done_o), 32'd1);
        check_output("byp_hold", 32'(core_hold_o), 32'd0);
        send_byte(SYNC_BYTE);
        send_byte(8'h00);
        check_output("byp_busy", 32'(busy_o), 32'd0);
        check_output("byp_stb", stb_seen, 32'd0);

        // Noise (including a mis-framed 0xA5) then the reference frame
        do_reset(1'b1);
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(SYNC_BYTE, 1'b1);
        repeat (4) @(negedge clk);
        check_output("noise_busy", 32'(busy_o), 32'd0);
        check_output("noise_err", 32'(err_o), 32'd0);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
        apply_stimulus(frame);
        model_frame(frame);
        check_output("norm_w0", exp_dat[0], 32'h1122_3344);
        check_frame("norm");

        // Bad checksum, then retry without reset
        do_reset(1'b1);
        frame[11] = 8'h67;
        apply_stimulus(frame);
        model_frame(frame);
        check_frame("badcs");
        frame[11] = 8'h66;
        apply_stimulus(frame);
        model_frame(frame);
        check_frame("retry");

        // LEN = 0
        do_reset(1'b1);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        apply_stimulus(frame);
        model_frame(frame);
        check_frame("len0");
        check_output("len0_stb", stb_seen, 32'd0);

        // LEN = MAX_WORDS + 1
        do_reset(1'b1);
        frame = '{8'hA5, 8'h01, 8'h40};
        apply_stimulus(frame);
        model_frame(frame);
        check_frame("lenmax");
        check_output("lenmax_busy", 32'(busy_o), 32'd0);

        // Randomized frames
        for (int t = 0; t < 4; t++) begin
            do_reset(1'b1);
            n = $urandom_range(1, 3);
            frame = '{8'hA5, 8'(n), 8'h00};
            b = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                frame.push_back(8'($urandom));
                b = b ^ frame[frame.size() - 1];
            end
            if ($urandom_range(0, 1) == 1)
                b = b ^ 8'(1 << $urandom_range(0, 7));
            frame.push_back(b);
            apply_stimulus(frame);
            model_frame(frame);
            check_frame("rand");
        end

        // Stalled ack: two more bytes arrive while the write is pending
        do_reset(1'b1);
        ack_enable = 1'b0;
        frame = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (frame[i]) send_byte(frame[i]);
        wait_stb("stall_stb");
        send_byte(8'h01);
        send_byte(8'h02);
        check_output("stall_hold_stb", 32'(stb_o), 32'd1);
        check_output("stall_err_early", 32'(err_o), 32'd0);
        ack_enable = 1'b1;
        repeat (40) @(negedge clk);
        check_output("stall_err", 32'(err_o), 32'd1);
        check_output("stall_hold", 32'(core_hold_o), 32'd1);
        check_output("stall_nwr", got_dat.size(), 32'd1);
        if (got_dat.size() > 0)
            check_output("stall_dat", got_dat[0], 32'hEFBE_ADDE);

        // Framing error during DATA
        do_reset(1'b1);
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11};
        foreach (frame[i]) send_byte(frame[i]);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check_output("ferr_err", 32'(err_o), 32'd1);
        check_output("ferr_done", 32'(done_o), 32'd0);

        // Reset while a write is stalled
        do_reset(1'b1);
        ack_enable = 1'b0;
        frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (frame[i]) send_byte(frame[i]);
        wait_stb("mid_stb");
        check_output("mid_adr", adr_o, BASE);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid_stb_drop", 32'(stb_o), 32'd0);
        check_output("mid_cyc_drop", 32'(cyc_o), 32'd0);
        check_output("mid_hold", 32'(core_hold_o), 32'd1);
        check_output("mid_adr0", adr_o, 32'd0);

        check_output("bus_ctl", bad_ctl, 32'd0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial boot loader sitting upstream of the on-chip RAM memory bus. On power-up in boot mode it holds the pipeline core in reset and receives a framed program image on the UART RX pin. It writes the image word-by-word into RAM as a Wishbone master, muxed ahead of BusSwitchMem. It releases the core only after a checksum-verified load.

## Interface
- CLOCK_FREQ, 50000000, clk_i frequency in Hz
- BAUD, 115200, serial bit rate; bit period DIV = CLOCK_FREQ/BAUD cycles (integer divide)
- LOAD_BASE, 32'h0000_0000, byte address of first loaded word
- MAX_WORDS, 16384, largest accepted word count
- clk_i  in  1  single clock for the block
- rst_i  in  1  reset, synchronous, active-low
- uart_rx_i  in  1  asynchronous serial input, 8N1, idle high
- boot_mode_i  in  1  1 = load image, 0 = bypass
- core_hold_o  out  1  1 = hold core/BIU in reset
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  32  write byte address
- dat_o  out  32  write data
- sel_o  out  4  byte selects, always 4'hF when stb_o=1
- ack_i  in  1  slave acknowledge
- busy_o  out  1  frame in progress (SYNC seen, not yet DONE/ERR)
- done_o  out  1  load completed, sticky until reset
- err_o  out  1  last frame failed

## Operation
- Frame: 0xA5, LEN_L, LEN_H (16-bit word count), LEN×4 data bytes (each word little-endian), CSUM = XOR of data bytes only (0x00 when LEN=0).
- FSM states: IDLE, SYNC, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: first cycle after reset. boot_mode_i=0 -> DONE with core_hold_o=0, done_o=1. Otherwise -> SYNC.
- SYNC: discard bytes ≠ 0xA5. On 0xA5, clear err_o, word index and checksum; -> LEN0.
- LEN1: LEN>MAX_WORDS -> ERR. LEN=0 -> CSUM. Otherwise -> DATA.
- DATA: shift bytes into the word. The 4th byte -> WRITE.
- WRITE: adr_o = LOAD_BASE + 4·index; hold cyc/stb/we until ack_i; then index++. index==LEN -> CSUM, else -> DATA.
- CSUM: a match -> DONE, a mismatch -> ERR.
- DONE: core_hold_o=0, done_o=1, bus idle, all RX ignored until reset.
- ERR: err_o=1, core_hold_o stays 1; the next cycle -> SYNC, allowing a retry.
- RX byte overrun: one-byte holding register. A new byte arriving while the holding register is still full (WRITE stalled) -> ERR; the in-flight write completes first.
- Framing error (stop bit 0): byte dropped. -> ERR if busy_o, else ignored.
- Checksum and length arithmetic: 8-bit XOR; index is 17 bits, no wrap.

## Timing
- Reset values: core_hold_o=1; cyc_o/stb_o/we_o/busy_o/done_o/err_o=0; adr_o/dat_o=0; sel_o=0.
- uart_rx_i passes through a 2-flop synchronizer.
- Start detect: falling edge. Sample at DIV/2, then every DIV cycles. The byte-valid pulse occurs in the stop-bit sample cycle.
- Bus request: cyc_o/stb_o rise the cycle after the 4th data byte is consumed.
- An ack_i in the same cycle stb_o rises ends the write, giving a minimum 1-cycle transfer. stb_o drops the cycle after ack_i. ack_i while stb_o=0 is ignored.
- core_hold_o falls and done_o rises in the same cycle as DONE entry: one cycle after the CSUM byte is consumed.
- rst_i low mid-transfer: all outputs return to reset values on the next clk_i edge, including dropping stb_o without waiting for ack.

## Structure
- Package boot_pkg: state enum, SYNC_BYTE=8'hA5, FRAME_HDR_LEN=3, helper function for DIV.
- Sub-module boot_uart_rx: synchronizer, baud counter, bit shifter. Outputs byte[7:0], valid, frame_err.
- boot_loader holds the FSM, holding register, word assembler, checksum and Wishbone master.
- Top-level wiring: core_hold_o is ORed into the core/BIU reset. The Wishbone outputs are muxed with the BIU mem port while core_hold_o=1.

## Test plan
- Bypass: boot_mode_i=0 at reset -> core_hold_o=0, done_o=1 within 2 cycles; no stb_o.
- Normal load: A5 02 00 44 33 22 11 EF BE AD DE 66 -> writes 0x11223344 @0x0 and 0xDEADBEEF @0x4, sel_o=F; then done_o=1, core_hold_o=0.
- Bad checksum: same frame with CSUM 0x67 -> err_o=1, core_hold_o=1. A following correct frame -> done_o=1, err_o=0.
- LEN=0 (A5 00 00 00) -> DONE with no bus cycle. LEN=MAX_WORDS+1 -> ERR after LEN_H.
- Stalled ack: ack_i held low across two further byte arrivals -> ERR once the write acks. Glitch/noise bytes before 0xA5 are ignored.
- Reset mid-write: rst_i low while stb_o=1 -> stb_o=0 and core_hold_o=1 next edge. Framing error during DATA -> ERR.
